// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Raster timing generator for 640x480@60 VGA (defaults), derived from a
//   system clock that is divided down to the pixel rate.
//
//   A pixel-rate enable advances a horizontal/vertical counter pair. Stage 1
//   registers the counters into the coordinates handed to the sprite logic
//   (vgax/vgay) plus the blanking and sync decodes. Stage 2 registers the
//   sprite pixel returned on pixel_in together with the sync decodes, so
//   video, hsync and vsync always leave this block aligned to each other,
//   exactly one pixel period after the coordinates that produced them.
//
// Ports
//   clk       in   1   system clock
//   rst       in   1   asynchronous reset, active-high
//   pixel_in  in   1   sprite pixel, combinational function of vgax/vgay
//   vgax      out  10  current column, 10'h3FF outside the active area
//   vgay      out  9   current row, 9'h1FF outside the active area
//   update    out  1   one-clk pulse per frame at the start of vertical blanking
//   hsync     out  1   horizontal sync, asserted level SYNC_POL
//   vsync     out  1   vertical sync, asserted level SYNC_POL
//   video     out  1   registered pixel, 0 during blanking
//
// Handshake: none. All outputs are plain registered levels; the only
// timing contract is that pixel_in must settle within one pixel period of
// a vgax/vgay change.
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_in,
  output logic [9:0] vgax,
  output logic [8:0] vgay,
  output logic       update,
  output logic       hsync,
  output logic       vsync,
  output logic       video
);

  // -------------------------------------------------------------------------
  // Derived constants, all held at the 10-bit counter width so every
  // comparison is an unsigned 10-bit compare.
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);

  // -------------------------------------------------------------------------
  // Pixel-rate enable
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic             w_pix_en;

  // With CLK_DIV=1 DIV_LAST is 0 and r_div never leaves 0, so the enable
  // is permanently high.
  assign w_pix_en = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       w_h_wrap;
  logic       w_v_wrap;

  assign w_h_wrap = (r_h == H_LAST_C);
  assign w_v_wrap = (r_v == V_LAST_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_en) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? 10'd0 : (r_v + 10'd1);
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 decodes (combinational from the counters)
  // -------------------------------------------------------------------------
  logic w_h_act;
  logic w_v_act;
  logic w_hs;
  logic w_vs;

  assign w_h_act = (r_h < H_ACT_C);
  assign w_v_act = (r_v < V_ACT_C);
  assign w_hs    = (r_h >= HS_BEG_C) && (r_h < HS_END_C);
  assign w_vs    = (r_v >= VS_BEG_C) && (r_v < VS_END_C);

  // -------------------------------------------------------------------------
  // Stage 1 registers: coordinates presented to the sprite logic
  // -------------------------------------------------------------------------
  logic [9:0] r_vgax;
  logic [8:0] r_vgay;
  logic       r_active_s1;
  logic       r_hs_s1;
  logic       r_vs_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vgax      <= '0;
      r_vgay      <= '0;
      r_active_s1 <= 1'b0;
      r_hs_s1     <= 1'b0;
      r_vs_s1     <= 1'b0;
    end else if (w_pix_en) begin
      r_vgax      <= w_h_act ? r_h : 10'h3FF;
      r_vgay      <= w_v_act ? r_v[8:0] : 9'h1FF;
      r_active_s1 <= w_h_act && w_v_act;
      r_hs_s1     <= w_hs;
      r_vs_s1     <= w_vs;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 registers: pixel and syncs leave together
  // -------------------------------------------------------------------------
  logic r_video;
  logic r_hsync;
  logic r_vsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_video <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else if (w_pix_en) begin
      // Blanking gate uses the stage-1 flag so a sprite that ignores the
      // 3FF/1FF markers still cannot drive video outside the active area.
      r_video <= r_active_s1 & pixel_in;
      r_hsync <= r_hs_s1 ? SYNC_POL : ~SYNC_POL;
      r_vsync <= r_vs_s1 ? SYNC_POL : ~SYNC_POL;
    end
  end

  // -------------------------------------------------------------------------
  // Frame update pulse
  // -------------------------------------------------------------------------
  // The enable edge that loads stage 1 from (h=0, v=V_ACTIVE) is the edge
  // where vgay moves from the last visible row to 1FF. Registering the
  // decode on that same edge makes update high for exactly the first clk
  // of vertical blanking.
  logic r_update;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_update <= 1'b0;
    end else begin
      r_update <= w_pix_en && (r_h == 10'd0) && (r_v == V_ACT_C);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign vgax   = r_vgax;
  assign vgay   = r_vgay;
  assign update = r_update;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;
  assign video  = r_video;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//   Two instances share clock and reset:
//     dut_f : default 640x480 timing, CLK_DIV=2, active-low syncs,
//             pixel_in = (vgax==5 && vgay==7)
//     dut_s : reduced 16x8 raster (25x15 total), CLK_DIV=3, active-high
//             syncs, pixel_in = 1, so whole frames fit in a short run
//   A time-based raster model predicts every output on every clk from the
//   number of clk edges since reset release; measured intervals are then
//   compared against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_vga_timing;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int   t_cnt = 0;    // posedges since reset release
  int   phase = 0;    // 0 before first release, 1 first run, 2 after mid-line reset
  bit   chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) t_cnt <= 0;
    else     t_cnt <= t_cnt + 1;
  end

  // ---------------- DUTs ----------------
  logic [9:0] vgax_f, vgax_s;
  logic [8:0] vgay_f, vgay_s;
  logic       upd_f, upd_s, hs_f, hs_s, vs_f, vs_s, vid_f, vid_s;
  logic       pin_f, pin_s;

  assign pin_f = (vgax_f == 10'd5) && (vgay_f == 9'd7);
  assign pin_s = 1'b1;

  vga_timing dut_f (
    .clk(clk), .rst(rst), .pixel_in(pin_f),
    .vgax(vgax_f), .vgay(vgay_f), .update(upd_f),
    .hsync(hs_f), .vsync(vs_f), .video(vid_f)
  );

  vga_timing #(
    .CLK_DIV(3),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .pixel_in(pin_s),
    .vgax(vgax_s), .vgay(vgay_s), .update(upd_s),
    .hsync(hs_s), .vsync(vs_s), .video(vid_s)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s t=%0d got=%0d expected=%0d", name, t_cnt, act, exp);
    end
  endtask

  // ---------------- raster model ----------------
  // Position p counts pixel periods since release. After the n-th enable
  // edge the coordinates show position n-1 and video/syncs show n-2.
  function automatic void model(
    input int cd, ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
    input bit pol, pm, input int t,
    output logic [9:0] ex, output logic [8:0] ey,
    output logic eu, ehs, evs, evid);
    int ht, vt, n, p1, h1, v1, p2, h2, v2;
    bit hs, vs;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    n  = t / cd;
    ex = '0; ey = '0; eu = 1'b0; ehs = ~pol; evs = ~pol; evid = 1'b0;
    if (n >= 1) begin
      p1 = (n - 1) % (ht * vt);
      h1 = p1 % ht;
      v1 = p1 / ht;
      ex = (h1 < ha) ? 10'(h1) : 10'h3FF;
      ey = (v1 < va) ? 9'(v1)  : 9'h1FF;
      eu = ((t % cd) == 0) && (h1 == 0) && (v1 == va);
    end
    if (n >= 2) begin
      p2 = (n - 2) % (ht * vt);
      h2 = p2 % ht;
      v2 = p2 / ht;
      hs = (h2 >= ha + hfp) && (h2 < ha + hfp + hsw);
      vs = (v2 >= va + vfp) && (v2 < va + vfp + vsw);
      ehs  = hs ? pol : ~pol;
      evs  = vs ? pol : ~pol;
      evid = (h2 < ha) && (v2 < va) && (pm ? ((h2 == 5) && (v2 == 7)) : 1'b1);
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [9:0] ex;
    logic [8:0] ey;
    logic eu, ehs, evs, evid;
    if (chk_en) begin
      model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b1, t_cnt, ex, ey, eu, ehs, evs, evid);
      chk("f_vgax",  32'(vgax_f), 32'(ex));
      chk("f_vgay",  32'(vgay_f), 32'(ey));
      chk("f_update", 32'(upd_f), 32'(eu));
      chk("f_hsync", 32'(hs_f),   32'(ehs));
      chk("f_vsync", 32'(vs_f),   32'(evs));
      chk("f_video", 32'(vid_f),  32'(evid));
      if (!hs_f || !vs_f) chk("f_video_in_sync", 32'(vid_f), 32'd0);

      model(3, 16, 2, 4, 3, 8, 2, 2, 3, 1'b1, 1'b0, t_cnt, ex, ey, eu, ehs, evs, evid);
      chk("s_vgax",  32'(vgax_s), 32'(ex));
      chk("s_vgay",  32'(vgay_s), 32'(ey));
      chk("s_update", 32'(upd_s), 32'(eu));
      chk("s_hsync", 32'(hs_s),   32'(ehs));
      chk("s_vsync", 32'(vs_s),   32'(evs));
      chk("s_video", 32'(vid_s),  32'(evid));
      if (hs_s || vs_s) chk("s_video_in_sync", 32'(vid_s), 32'd0);

      if (rst) begin
        chk("f_update_in_rst", 32'(upd_f), 32'd0);
        chk("s_update_in_rst", 32'(upd_s), 32'd0);
      end
    end
  end

  // ---------------- interval measurements (first run only) ----------------
  logic       p_hs_f = 1'b1, p_vs_s = 1'b0;
  logic [9:0] p_vgax_f = 10'd0;
  int f_fall[2] = '{-1, -1};
  int n_fall = 0;
  int f_rise = -1;
  int f_onset1 = -1;
  int f_vid_cnt = 0, f_vid_first = -1;
  int s_rise[2] = '{-1, -1};
  int n_srise = 0;
  int s_fall = -1;
  int s_vid_cnt = 0;
  int s_upd_cnt = 0, f_upd_cnt = 0;

  always @(negedge clk) begin
    if (phase == 1 && !rst) begin
      if (p_hs_f && !hs_f && n_fall < 2) begin f_fall[n_fall] = t_cnt; n_fall++; end
      if (!p_hs_f && hs_f && n_fall >= 1 && f_rise < 0) f_rise = t_cnt;
      if (p_vgax_f == 10'h3FF && vgax_f == 10'd0 && f_onset1 < 0) f_onset1 = t_cnt;
      if (vid_f) begin
        if (f_vid_first < 0) f_vid_first = t_cnt;
        f_vid_cnt++;
      end
      if (!p_vs_s && vs_s && n_srise < 2) begin s_rise[n_srise] = t_cnt; n_srise++; end
      if (p_vs_s && !vs_s && n_srise >= 1 && s_fall < 0) s_fall = t_cnt;
      if (n_srise == 1 && vid_s) s_vid_cnt++;
      if (upd_s) s_upd_cnt++;
      if (upd_f) f_upd_cnt++;
    end
    p_hs_f   = hs_f;
    p_vs_s   = vs_s;
    p_vgax_f = vgax_f;
  end

  // ---------------- sequence ----------------
  initial begin
    #2 rst = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    phase = 1;

    // First run: 16600 clk puts dut_f at h=300 of line 10.
    repeat (16600) @(negedge clk);
    #2 rst = 1'b1;
    phase = 2;
    #1;
    chk("async_f_vgax",  32'(vgax_f), 32'd0);
    chk("async_f_vgay",  32'(vgay_f), 32'd0);
    chk("async_f_video", 32'(vid_f),  32'd0);
    chk("async_f_hsync", 32'(hs_f),   32'd1);
    chk("async_f_vsync", 32'(vs_f),   32'd1);
    chk("async_s_hsync", 32'(hs_s),   32'd0);
    chk("async_s_vsync", 32'(vs_s),   32'd0);
    chk("async_s_video", 32'(vid_s),  32'd0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2000) @(negedge clk);

    // Hand-computed literals.
    chk("f_first_hs_fall",   32'(f_fall[0]), 32'd1316);
    chk("f_hs_period",       32'(f_fall[1] - f_fall[0]), 32'd1600);
    chk("f_hs_low_width",    32'(f_rise - f_fall[0]), 32'd192);
    chk("f_vgax0_to_fall",   32'(f_fall[1] - f_onset1), 32'd1314);
    chk("f_video_pulse_t",   32'(f_vid_first), 32'd11214);
    chk("f_video_pulse_len", 32'(f_vid_cnt), 32'd2);
    chk("f_update_count",    32'(f_upd_cnt), 32'd0);
    chk("s_first_vs_rise",   32'(s_rise[0]), 32'd756);
    chk("s_vs_period",       32'(s_rise[1] - s_rise[0]), 32'd1125);
    chk("s_vs_width",        32'(s_fall - s_rise[0]), 32'd150);
    chk("s_video_per_frame", 32'(s_vid_cnt), 32'd384);
    chk("s_update_count",    32'(s_upd_cnt), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
